// File: rtl/grp_pingpong_ctrl.sv
// ---------------------------------------------------------------------------
// grp_pingpong_ctrl
//
// Purpose:
//   Sequences the two group buffers (m0/m1) between the frame filler (writer)
//   and the M8 frame former (reader). Owns the bank-select bit, routes the
//   write/read strobes and read data to the right bank, swaps banks only when
//   the writer has completed a group, and otherwise detects and counts
//   underruns. Kicks the writer at the start of each fill and runs a
//   fill-timeout watchdog. All logic is on clk (clk80 domain).
//
// Ports:
//   clk           in   system clock
//   reset         in   synchronous, active-high reset
//   wr_done       in   pulse: current write bank holds a complete group
//   wr_en         in   writer word write strobe
//   rd_en         in   reader word read strobe
//   rd_swap_req   in   pulse from the reader at the group boundary
//   m0_q, m1_q    in   bank 0 / bank 1 read data
//   wr_start      out  pulse: writer begins filling the write bank
//   buf_sel       out  read bank (0 = read m0/write m1, 1 = read m1/write m0)
//   m0_we, m1_we  out  bank write strobes
//   m0_re, m1_re  out  bank read strobes
//   rd_data       out  read data of the selected bank
//   underrun      out  high for the whole group that is being re-read
//   underrun_cnt  out  saturating count of underruns
//   fill_timeout  out  sticky watchdog flag
//
// Optional feature (macro GRP_UNDERRUN_ZERO_EN):
//   When defined, rd_data is forced to zero while underrun=1 so the frame
//   carries zeros instead of a stale group. When undefined, the selected bank
//   always passes through and the stale group is repeated.
// ---------------------------------------------------------------------------
module grp_pingpong_ctrl #(
  parameter int          CNT_W        = 16,
  parameter logic [23:0] FILL_TIMEOUT = 24'd8_000_000,
  parameter int          DATA_W       = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_done,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic              rd_swap_req,
  input  logic [DATA_W-1:0] m0_q,
  input  logic [DATA_W-1:0] m1_q,
  output logic              wr_start,
  output logic              buf_sel,
  output logic              m0_we,
  output logic              m1_we,
  output logic              m0_re,
  output logic              m1_re,
  output logic [DATA_W-1:0] rd_data,
  output logic              underrun,
  output logic [CNT_W-1:0]  underrun_cnt,
  output logic              fill_timeout
);

  typedef enum logic [1:0] {
    START   = 2'd0,
    FILLING = 2'd1,
    READY   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t      state;
  logic [23:0] tmo_cnt;

  // Sequencer: kicks the writer, waits for a complete group, then swaps on
  // the reader's request. A swap request that arrives before the group is
  // complete keeps the old bank and flags an underrun; the fill carries on.
  // The timeout counter parks at FILL_TIMEOUT so the sticky flag is set once
  // the fill has lasted that many cycles past the kick.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= START;
      tmo_cnt      <= '0;
      wr_start     <= 1'b0;
      buf_sel      <= 1'b0;
      underrun     <= 1'b0;
      underrun_cnt <= '0;
      fill_timeout <= 1'b0;
    end else begin
      wr_start <= 1'b0;
      case (state)
        START: begin
          wr_start <= 1'b1;
          tmo_cnt  <= '0;
          state    <= FILLING;
          // wr_done is meaningless here, so any swap request is an underrun
          if (rd_swap_req) begin
            underrun <= 1'b1;
            if (underrun_cnt != CNT_MAX)
              underrun_cnt <= underrun_cnt + 1'b1;
          end
        end

        FILLING: begin
          if (tmo_cnt == FILL_TIMEOUT)
            fill_timeout <= 1'b1;
          else
            tmo_cnt <= tmo_cnt + 24'd1;

          // A group finishing in the same cycle as the swap request counts
          // as complete, so it swaps rather than underruns
          if (wr_done && rd_swap_req) begin
            buf_sel  <= ~buf_sel;
            underrun <= 1'b0;
            state    <= START;
          end else if (wr_done) begin
            state <= READY;
          end else if (rd_swap_req) begin
            underrun <= 1'b1;
            if (underrun_cnt != CNT_MAX)
              underrun_cnt <= underrun_cnt + 1'b1;
          end
        end

        READY: begin
          if (rd_swap_req) begin
            buf_sel  <= ~buf_sel;
            underrun <= 1'b0;
            state    <= START;
          end
        end

        default: state <= START;
      endcase
    end
  end

  // Bank routing: the writer always targets the bank the reader is not
  // using. Everything is held at zero while reset is asserted.
  always_comb begin
    m0_we   = 1'b0;
    m1_we   = 1'b0;
    m0_re   = 1'b0;
    m1_re   = 1'b0;
    rd_data = '0;
    if (!reset) begin
      m0_we   = wr_en & buf_sel;
      m1_we   = wr_en & ~buf_sel;
      m0_re   = rd_en & ~buf_sel;
      m1_re   = rd_en & buf_sel;
      rd_data = buf_sel ? m1_q : m0_q;
`ifdef GRP_UNDERRUN_ZERO_EN
      if (underrun)
        rd_data = '0;
`endif
    end
  end

endmodule

// File: tb/tb_grp_pingpong_ctrl.sv
// ---------------------------------------------------------------------------
// tb_grp_pingpong_ctrl
//
// Self-checking bench for grp_pingpong_ctrl. A stimulus process drives one
// cycle at a time, pushes the expected outputs for that cycle into a
// scoreboard queue and advances a behavioural model of the group sequencing;
// a monitor pops and compares on the falling edge. Small parameters
// (CNT_W=4, FILL_TIMEOUT=16) make saturation and timeout reachable.
// ---------------------------------------------------------------------------
module tb_grp_pingpong_ctrl;

  localparam int          CNT_W  = 4;
  localparam int          DATA_W = 12;
  localparam int          TMO    = 16;
  localparam int          UMAX   = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              wr_done, wr_en, rd_en, rd_swap_req;
  logic [DATA_W-1:0] m0_q, m1_q;
  logic              wr_start, buf_sel, m0_we, m1_we, m0_re, m1_re;
  logic [DATA_W-1:0] rd_data;
  logic              underrun;
  logic [CNT_W-1:0]  underrun_cnt;
  logic              fill_timeout;

  typedef struct {
    logic              ws, sel, und, tmo;
    logic [CNT_W-1:0]  ucnt;
    logic              m0we, m1we, m0re, m1re;
    logic [DATA_W-1:0] rd;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // Behavioural model: where the writer is in its group and what the
  // reader sees. kick_due means a fill will be launched this cycle.
  bit sel_m, und_m, tmo_m, ws_m, kick_due, group_full;
  int ucnt_m, fill_age;

  grp_pingpong_ctrl #(
    .CNT_W(CNT_W),
    .FILL_TIMEOUT(24'(TMO)),
    .DATA_W(DATA_W)
  ) dut (
    .clk(clk), .reset(reset), .wr_done(wr_done), .wr_en(wr_en),
    .rd_en(rd_en), .rd_swap_req(rd_swap_req), .m0_q(m0_q), .m1_q(m1_q),
    .wr_start(wr_start), .buf_sel(buf_sel), .m0_we(m0_we), .m1_we(m1_we),
    .m0_re(m0_re), .m1_re(m1_re), .rd_data(rd_data), .underrun(underrun),
    .underrun_cnt(underrun_cnt), .fill_timeout(fill_timeout)
  );

  always #5 clk = ~clk;

  task automatic modelReset();
    sel_m = 0; und_m = 0; tmo_m = 0; ws_m = 0;
    ucnt_m = 0; fill_age = 0; kick_due = 1; group_full = 0;
  endtask

  // Drive one cycle, record what the DUT must show in it, advance the model
  task automatic applyStimulus(input bit rst, input bit done, input bit swap);
    exp_t e;
    bit   filling, do_swap;
    reset       = rst;
    wr_done     = done;
    rd_swap_req = swap;
    wr_en       = 1'($urandom);
    rd_en       = 1'($urandom);
    m0_q        = DATA_W'($urandom);
    m1_q        = DATA_W'($urandom);

    e.ws   = ws_m;
    e.sel  = sel_m;
    e.und  = und_m;
    e.tmo  = tmo_m;
    e.ucnt = CNT_W'(ucnt_m);
    e.m0we = !rst && wr_en && sel_m;
    e.m1we = !rst && wr_en && !sel_m;
    e.m0re = !rst && rd_en && !sel_m;
    e.m1re = !rst && rd_en && sel_m;
    if (rst) e.rd = '0;
    else     e.rd = sel_m ? m1_q : m0_q;
`ifdef GRP_UNDERRUN_ZERO_EN
    if (!rst && und_m) e.rd = '0;
`endif
    sb.push_back(e);

    if (rst) begin
      modelReset();
    end else begin
      filling = !kick_due && !group_full;
      do_swap = swap && (group_full || (filling && done));
      ws_m = kick_due;
      if (filling) begin
        if (fill_age >= TMO) tmo_m = 1;
        else fill_age++;
      end
      if (do_swap) begin
        sel_m = !sel_m;
        und_m = 0;
        kick_due = 1;
        group_full = 0;
      end else begin
        if (swap) begin
          und_m = 1;
          if (ucnt_m < UMAX) ucnt_m++;
        end
        if (kick_due) begin
          kick_due = 0;
          fill_age = 0;
        end else if (filling && done) begin
          group_full = 1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every presented cycle has a queued expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput("wr_start", 32'(wr_start), 32'(e.ws));
        checkOutput("buf_sel", 32'(buf_sel), 32'(e.sel));
        checkOutput("underrun", 32'(underrun), 32'(e.und));
        checkOutput("underrun_cnt", 32'(underrun_cnt), 32'(e.ucnt));
        checkOutput("fill_timeout", 32'(fill_timeout), 32'(e.tmo));
        checkOutput("m0_we", 32'(m0_we), 32'(e.m0we));
        checkOutput("m1_we", 32'(m1_we), 32'(e.m1we));
        checkOutput("m0_re", 32'(m0_re), 32'(e.m0re));
        checkOutput("m1_re", 32'(m1_re), 32'(e.m1re));
        checkOutput("rd_data", 32'(rd_data), 32'(e.rd));
      end
    end
  end

  initial begin
    int hold;
    reset = 1'b1; wr_done = 0; wr_en = 0; rd_en = 0; rd_swap_req = 0;
    m0_q = '0; m1_q = '0;
    repeat (2) @(posedge clk);
    #1;
    modelReset();

    // Normal group: done at 100, swap at 200
    applyStimulus(1, 0, 0);
    for (int c = 0; c < 230; c++) applyStimulus(0, c == 100, c == 200);

    // Early swap request underruns, later complete group swaps
    applyStimulus(1, 0, 0);
    for (int c = 0; c < 150; c++) applyStimulus(0, c == 80, c == 50 || c == 120);

    // Completion and swap request in the same FILLING cycle
    applyStimulus(1, 0, 0);
    for (int c = 0; c < 40; c++) applyStimulus(0, c == 10, c == 10);

    // Repeated underruns saturate the counter, then reset mid-fill
    applyStimulus(1, 0, 0);
    for (int c = 0; c < 2 * ((1 << CNT_W) + 3) + 4; c++) applyStimulus(0, 0, c % 2 == 1);
    applyStimulus(1, 0, 0);
    for (int c = 0; c < 20; c++) applyStimulus(0, 0, 0);

    // Randomised traffic with occasional resets
    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      if (hold == 0 && $urandom_range(399) == 0) hold = $urandom_range(2, 1);
      applyStimulus(hold > 0, $urandom_range(14) == 0, $urandom_range(19) == 0);
      if (hold > 0) hold--;
    end

    for (int w = 0; w < 10 && sb.size() > 0; w++) @(posedge clk);
    if (sb.size() > 0) begin
      failures++;
      checks++;
      $display("[TB] FAIL drain actual=%0d expected=0 pending entries", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/grp_pingpong_ctrl.md
Name: grp_pingpong_ctrl

Overview:
- Sequences the two group buffers (m0/m1) that sit between the frame filler (writer, clk80 side) and the M8 frame former (reader).
- Owns the bank-select bit and routes write enables, read enables and read data to the correct bank.
- Swaps banks only when the writer has finished a complete group. Otherwise it detects and counts underruns.
- Kicks the writer at the start of every fill and runs a fill-timeout watchdog.

Parameters:
- CNT_W, 16, width of the saturating underrun counter.
- FILL_TIMEOUT, 24'd8_000_000, max clk cycles from wr_start to wr_done before fill_timeout is set.
- DATA_W, 12, group buffer word width.

Ports:
- clk  in  1  system clock (clk80 domain); all logic is on this clock.
- reset  in  1  synchronous, active-high reset.
- wr_done  in  1  one-cycle pulse from the writer: current write bank holds a complete group.
- wr_en  in  1  writer word write strobe.
- rd_en  in  1  reader word read strobe.
- rd_swap_req  in  1  one-cycle pulse from the reader at the group boundary.
- m0_q  in  DATA_W  bank 0 read data.
- m1_q  in  DATA_W  bank 1 read data.
- wr_start  out  1  one-cycle pulse: writer begins filling the write bank.
- buf_sel  out  1  read bank (0 = read m0/write m1, 1 = read m1/write m0).
- m0_we, m1_we, m0_re, m1_re  out  1  bank strobes.
- rd_data  out  DATA_W  read data of the selected bank.
- underrun  out  1  high for the whole group that is being re-read.
- underrun_cnt  out  CNT_W  saturating count of underruns.
- fill_timeout  out  1  sticky watchdog flag.

Behaviour:
- Reset values: buf_sel=0, wr_start=0, underrun=0, underrun_cnt=0, fill_timeout=0, state=START.
  - While reset=1, all bank strobes are 0 and rd_data=0.
- States:
  - START: pulse wr_start for 1 cycle, clear the timeout counter, go to FILLING.
    - First wr_start occurs the first cycle after reset deasserts.
  - FILLING: timeout counter increments each cycle.
    - wr_done -> READY.
    - Counter reaches FILL_TIMEOUT -> set fill_timeout (sticky), stay in FILLING.
  - READY: waits for rd_swap_req.
    - On rd_swap_req: toggle buf_sel, clear underrun, go to START.
    - The new buf_sel is visible the next cycle; wr_start follows one cycle after that.
- Underrun: rd_swap_req while in START or FILLING, without a simultaneous wr_done.
  - buf_sel is unchanged (reader repeats the old group).
  - underrun=1 from the next cycle.
  - underrun_cnt increments, saturating at all-ones.
  - The fill continues uninterrupted.
- Simultaneous wr_done and rd_swap_req in FILLING: treated as a complete group, not an underrun. Swap occurs exactly as in READY.
- Ignored events:
  - wr_done outside FILLING is ignored.
  - rd_swap_req in READY while underrun=1 is a normal swap and clears underrun.
- Routing (combinational, gated by reset):
  - m0_we = wr_en & buf_sel; m1_we = wr_en & ~buf_sel.
  - m0_re = rd_en & ~buf_sel; m1_re = rd_en & buf_sel.
  - rd_data = buf_sel ? m1_q : m0_q.
- buf_sel changes only on a swap; never mid-group.
- Reset mid-operation: state machine aborts to START with all reset values. Counters and flags clear.

Optional Feature:
- Macro: GRP_UNDERRUN_ZERO_EN.
- Defined: while underrun=1, rd_data is forced to 0, so the frame carries zeros instead of a stale group. Bank strobes are unchanged.
- Not defined: rd_data always passes the selected bank, so a stale group is repeated.

Test Plan:
- Release reset -> wr_start pulses at cycle 1. After wr_done at cycle 100 and rd_swap_req at 200: buf_sel 0->1 at 201, wr_start at 202, underrun_cnt=0.
- rd_swap_req at cycle 50 with no wr_done yet -> buf_sel stays 0, underrun=1, underrun_cnt=1.
  - wr_done at 80 then rd_swap_req at 120 -> buf_sel=1, underrun=0.
- wr_done and rd_swap_req in the same cycle during FILLING -> swap, underrun_cnt unchanged.
- FILL_TIMEOUT=16 and no wr_done -> fill_timeout=1 at cycle 17 after wr_start; stays 1 until reset.
- buf_sel=1, wr_en=1, rd_en=1, m1_q=12'hABC -> m0_we=1, m1_re=1, m1_we=0, m0_re=0, rd_data=12'hABC.
  - With GRP_UNDERRUN_ZERO_EN defined and underrun=1 -> rd_data=0.
- Force 2^CNT_W+3 underruns -> underrun_cnt saturates at all-ones.
  - Reset asserted mid-FILLING -> all outputs return to reset values the next cycle.
